// File: rtl/jpeg_seq_pkg.sv
// Shared state encoding, error-bit positions and code-word width for the JPEG frame sequencer.
// Imported by the sequencer top; carries no logic.
package jpeg_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_FEED,
    ST_DRAIN,
    ST_DONE,
    ST_ERROR
  } seq_state_t;

  localparam int ERR_UNDERRUN = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_TIMEOUT  = 2;

  localparam int CODE_W = 20;

endpackage

// File: rtl/jpeg_code_fifo.sv
// Show-ahead synchronous FIFO with flush: head word is valid whenever empty is low.
// Latency: a push shows at the head the next cycle; a push into a full FIFO is taken only with a same-cycle pop.
module jpeg_code_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 20
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign full     = (cnt == (AW+1)'(DEPTH));
  assign empty    = (cnt == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  // Head reads as zero when empty so the output is clean out of reset.
  assign head_dat = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/jpeg_frame_sequencer.sv
// Streams one frame into the JPEG encoder one pixel per clock, buffers its codes, reports status.
// Latency: enc_start 1 cycle after cfg_go, pixel on enc_* 1 cycle after acceptance; no backpressure to the encoder.
// JPEG_SEQ_TIMEOUT_EN adds the DRAIN timeout counter and ERROR state.
module jpeg_frame_sequencer
  import jpeg_seq_pkg::*;
#(
  parameter int IMG_WIDTH      = 64,
  parameter int IMG_HEIGHT     = 64,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                                  wb_clk_i,
  input  logic                                  wb_rst_i,
  input  logic                                  cfg_go,
  input  logic                                  cfg_abort,
  input  logic                                  pix_valid,
  output logic                                  pix_ready,
  input  logic [23:0]                           pix_rgb,
  output logic                                  enc_start,
  output logic [7:0]                            enc_r,
  output logic [7:0]                            enc_g,
  output logic [7:0]                            enc_b,
  input  logic [15:0]                           enc_out_code,
  input  logic [3:0]                            enc_out_len,
  input  logic                                  enc_out_valid,
  input  logic                                  enc_img_done,
  output logic                                  code_valid,
  input  logic                                  code_ready,
  output logic [CODE_W-1:0]                     code_data,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            error,
  output logic [$clog2(IMG_WIDTH*IMG_HEIGHT):0] pix_count
);

  localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
  localparam int PCW  = $clog2(NPIX) + 1;

  seq_state_t state;
  seq_state_t state_nxt;
  logic       early_done;
  logic [2:0] err_q;
  logic       fifo_push;
  logic       fifo_flush;
  logic       fifo_full;
  logic       fifo_empty;
  logic       overflow;

`ifdef JPEG_SEQ_TIMEOUT_EN
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TCW-1:0] drain_cnt;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cfg_go) state_nxt = ST_START;
      ST_START: state_nxt = ST_FEED;
      ST_FEED:  if (pix_count == PCW'(NPIX - 1)) state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (enc_img_done || early_done) state_nxt = ST_DONE;
`ifdef JPEG_SEQ_TIMEOUT_EN
        else if (drain_cnt == TCW'(TIMEOUT_CYCLES - 1)) state_nxt = ST_ERROR;
`endif
      end
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERROR: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (cfg_abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    pix_ready = (state == ST_FEED);
    enc_start = (state == ST_START) && !cfg_abort;
  end

  // Codes are only accepted while a frame is in flight; abort and a new frame both empty the FIFO.
  assign fifo_flush = cfg_abort || (state == ST_IDLE && cfg_go);
  assign fifo_push  = enc_out_valid && (state != ST_IDLE) && !cfg_abort;
  assign overflow   = fifo_push && fifo_full && !(code_ready && code_valid);
  assign code_valid = !fifo_empty;
  assign error      = err_q;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      enc_r      <= '0;
      enc_g      <= '0;
      enc_b      <= '0;
      pix_count  <= '0;
      done       <= 1'b0;
      err_q      <= '0;
      early_done <= 1'b0;
    end else begin
      if (state == ST_IDLE && cfg_go && !cfg_abort) begin
        done       <= 1'b0;
        err_q      <= '0;
        pix_count  <= '0;
        early_done <= 1'b0;
      end
      // A missing source pixel re-issues the held one; the frame keeps its cycle count.
      if (state == ST_FEED && !cfg_abort) begin
        pix_count <= pix_count + PCW'(1);
        if (pix_valid) {enc_r, enc_g, enc_b} <= pix_rgb;
        else           err_q[ERR_UNDERRUN] <= 1'b1;
      end
      if ((state == ST_START || state == ST_FEED) && enc_img_done) early_done <= 1'b1;
      if (overflow) err_q[ERR_OVERFLOW] <= 1'b1;
      if (state == ST_DONE && !cfg_abort) done <= 1'b1;
`ifdef JPEG_SEQ_TIMEOUT_EN
      if (state == ST_ERROR && !cfg_abort) err_q[ERR_TIMEOUT] <= 1'b1;
`endif
    end
  end

`ifdef JPEG_SEQ_TIMEOUT_EN
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) drain_cnt <= '0;
    else          drain_cnt <= (state == ST_DRAIN) ? drain_cnt + TCW'(1) : '0;
  end
`endif

  jpeg_code_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CODE_W)
  ) u_code_fifo (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_dat ({enc_out_code, enc_out_len}),
    .pop      (code_ready),
    .head_dat (code_data),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_jpeg_frame_sequencer.sv
// Bench for jpeg_frame_sequencer on an 8x8 frame: a frame-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
`timescale 1ns/1ps
module tb_jpeg_frame_sequencer;

  localparam int W     = 8;
  localparam int H     = 8;
  localparam int NPIX  = W * H;
  localparam int DEPTH = 16;
  localparam int TMO   = 32;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        cfg_go = 1'b0, cfg_abort = 1'b0;
  logic        pix_valid = 1'b0, pix_ready;
  logic [23:0] pix_rgb = '0;
  logic        enc_start;
  logic [7:0]  enc_r, enc_g, enc_b;
  logic [15:0] enc_out_code = '0;
  logic [3:0]  enc_out_len = '0;
  logic        enc_out_valid = 1'b0, enc_img_done = 1'b0;
  logic        code_valid, code_ready = 1'b0;
  logic [19:0] code_data;
  logic        busy, done;
  logic [2:0]  error;
  logic [6:0]  pix_count;

  always #5 wb_clk_i = ~wb_clk_i;

  jpeg_frame_sequencer #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .cfg_go(cfg_go), .cfg_abort(cfg_abort),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgb(pix_rgb), .enc_start(enc_start),
    .enc_r(enc_r), .enc_g(enc_g), .enc_b(enc_b), .enc_out_code(enc_out_code),
    .enc_out_len(enc_out_len), .enc_out_valid(enc_out_valid), .enc_img_done(enc_img_done),
    .code_valid(code_valid), .code_ready(code_ready), .code_data(code_data), .busy(busy),
    .done(done), .error(error), .pix_count(pix_count)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] pix_of(input int p);
    logic [7:0] v;
    v = 8'(p);
    return {v, v ^ 8'hA5, 8'd255 - v};
  endfunction

  // Frame-level reference: where the frame is, what the encoder was last given, what the FIFO holds.
  typedef enum int {P_IDLE, P_START, P_FEED, P_DRAIN, P_DONE, P_ERROR} phase_t;
  phase_t      ph = P_IDLE;
  int          m_issued = 0;
  logic [23:0] m_pix = '0;
  logic        m_done = 1'b0;
  logic [2:0]  m_err = '0;
  logic        m_early = 1'b0;
  int          m_wait = 0;
  logic [19:0] q[$];
  logic        chk_en = 1'b0;
  int          start_seen = 0;
  logic [7:0]  hist [NPIX];

  always @(posedge wb_clk_i) begin
    logic pop, push, full;
    if (wb_rst_i) begin
      ph = P_IDLE; m_issued = 0; m_pix = '0; m_done = 1'b0; m_err = '0;
      m_early = 1'b0; m_wait = 0; q.delete();
    end else begin
      pop  = code_ready && (q.size() != 0);
      push = enc_out_valid && (ph != P_IDLE) && !cfg_abort;
      if (cfg_abort || (ph == P_IDLE && cfg_go)) q.delete();
      else begin
        full = (q.size() >= DEPTH);
        if (push && full && !pop) m_err[1] = 1'b1;
        if (pop) void'(q.pop_front());
        if (push && (!full || pop)) q.push_back({enc_out_code, enc_out_len});
      end
      if ((ph == P_START || ph == P_FEED) && enc_img_done) m_early = 1'b1;
      if (cfg_abort) ph = P_IDLE;
      else begin
        case (ph)
          P_IDLE: if (cfg_go) begin
            m_done = 1'b0; m_err = '0; m_issued = 0; m_early = 1'b0; ph = P_START;
          end
          P_START: ph = P_FEED;
          P_FEED: begin
            if (pix_valid) m_pix = pix_rgb;
            else           m_err[0] = 1'b1;
            m_issued++;
            if (m_issued == NPIX) begin ph = P_DRAIN; m_wait = 0; end
          end
          P_DRAIN: begin
            if (enc_img_done || m_early) ph = P_DONE;
            else begin
              m_wait++;
`ifdef JPEG_SEQ_TIMEOUT_EN
              if (m_wait == TMO) ph = P_ERROR;
`endif
            end
          end
          P_DONE:  begin m_done = 1'b1; ph = P_IDLE; end
          P_ERROR: begin m_err[2] = 1'b1; ph = P_IDLE; end
          default: ph = P_IDLE;
        endcase
      end
    end
  end

  always @(negedge wb_clk_i) begin
    if (chk_en) begin
      chk("busy", busy, ph != P_IDLE);
      chk("pix_ready", pix_ready, ph == P_FEED);
      chk("enc_start", enc_start, (ph == P_START) && !cfg_abort);
      chk("enc_rgb", {enc_r, enc_g, enc_b}, m_pix);
      chk("pix_count", pix_count, m_issued);
      chk("done", done, m_done);
      chk("error", error, m_err);
      chk("code_valid", code_valid, q.size() != 0);
      if (q.size() != 0) chk("code_data", code_data, q[0]);
      if (enc_start) start_seen++;
    end
  end

  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask

  // Entered #1 after a rising edge; returns #1 into the first DRAIN cycle (or into FEED cycle stop_at).
  task automatic run_frame(input int drop_at, input int drop_len, input int n_strobe,
                           input int pop_at, input int stop_at);
    int p;
    logic v;
    p = 0;
    cfg_go = 1'b1; tick(); cfg_go = 1'b0;
    tick();
    for (int c = 0; c < NPIX && c != stop_at; c++) begin
      v = !(c >= drop_at && c < drop_at + drop_len);
      pix_valid     = v;
      pix_rgb       = pix_of(p);
      enc_out_valid = (c < n_strobe);
      enc_out_code  = 16'(16'h100 + c);
      enc_out_len   = 4'(c);
      code_ready    = (c == pop_at);
      tick();
      hist[c] = enc_r;
      if (v) p++;
    end
    pix_valid = 1'b0; enc_out_valid = 1'b0; code_ready = 1'b0;
  endtask

  task automatic finish_frame(input int delay);
    repeat (delay) tick();
    enc_img_done = 1'b1; tick(); enc_img_done = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_code_valid", code_valid, 0);
    chk("rst_code_data", code_data, 0);
    chk("rst_enc_rgb", {enc_r, enc_g, enc_b}, 0);

    // Reset in the middle of FEED
    run_frame(-1, 0, 5, -1, 20);
    chk("midfeed_count", pix_count, 20);
    wb_rst_i = 1'b1; tick(); wb_rst_i = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_count", pix_count, 0);
    chk("midrst_code_valid", code_valid, 0);
    chk("midrst_enc_rgb", {enc_r, enc_g, enc_b}, 0);
    tick();

    // Clean frame, img_done 5 cycles after the last pixel
    start_seen = 0;
    run_frame(-1, 0, 6, 3, -1);
    finish_frame(4);
    chk("frame_start_pulses", start_seen, 1);
    chk("frame_done", done, 1);
    chk("frame_error", error, 0);
    chk("frame_busy", busy, 0);
    chk("frame_count", pix_count, 64);
    chk("frame_pix0", hist[0], 0);
    chk("frame_pix9", hist[9], 9);
    chk("frame_pix63", hist[63], 63);

    // Source stalls for two cycles at pixel 10
    run_frame(10, 2, 0, -1, -1);
    finish_frame(0);
    chk("udr_error", error, 3'b001);
    chk("udr_done", done, 1);
    chk("udr_pix10", hist[10], 9);
    chk("udr_pix11", hist[11], 9);
    chk("udr_pix12", hist[12], 10);
    chk("udr_pix63", hist[63], 61);
    chk("udr_count", pix_count, 64);

    // 17 codes into a 16-deep FIFO with no consumer
    run_frame(-1, 0, 17, -1, -1);
    finish_frame(0);
    chk("ovf_error", error, 3'b010);
    code_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("ovf_word_valid", code_valid, 1);
      chk("ovf_word", code_data, {16'(16'h100 + i), 4'(i)});
      tick();
    end
    code_ready = 1'b0;
    chk("ovf_empty", code_valid, 0);

    // Same, with a pop on the 17th strobe
    run_frame(-1, 0, 17, 16, -1);
    finish_frame(0);
    chk("nov_error", error, 3'b000);
    code_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("nov_word", code_data, {16'(16'h100 + i), 4'(i)});
      tick();
    end
    code_ready = 1'b0;
    chk("nov_empty", code_valid, 0);

    // No img_done: timeout to ERROR, or wait until aborted
    run_frame(-1, 0, 0, -1, -1);
`ifdef JPEG_SEQ_TIMEOUT_EN
    repeat (31) tick();
    chk("tmo_still_drain", busy, 1);
    repeat (5) tick();
    chk("tmo_error", error, 3'b100);
    chk("tmo_done", done, 0);
    chk("tmo_busy", busy, 0);
`else
    repeat (100) tick();
    chk("notmo_busy", busy, 1);
    chk("notmo_error", error, 3'b000);
    cfg_abort = 1'b1; tick(); cfg_abort = 1'b0;
    chk("notmo_abort_busy", busy, 0);
`endif

    // Abort and go together during FEED
    run_frame(-1, 0, 5, -1, 30);
    chk("abt_pre_valid", code_valid, 1);
    cfg_abort = 1'b1; cfg_go = 1'b1; tick();
    cfg_abort = 1'b0; cfg_go = 1'b0;
    chk("abt_busy", busy, 0);
    chk("abt_flushed", code_valid, 0);
    tick();
    chk("abt_go_ignored", busy, 0);
    repeat (2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
